// File: rtl/msg_pkg.sv
// Shared definitions for the message entry writer: character codes,
// the a..g segment table and the entry FSM encoding.
package msg_pkg;

    localparam logic [2:0] CH_BLANK = 3'd0;
    localparam logic [2:0] CH_0     = 3'd1;
    localparam logic [2:0] CH_1     = 3'd2;
    localparam logic [2:0] CH_E     = 3'd3;
    localparam logic [2:0] CH_D     = 3'd4;
    localparam logic [2:0] CH_H     = 3'd5;
    localparam logic [2:0] CH_L     = 3'd6;
    localparam logic [2:0] CH_P     = 3'd7;

    localparam int NUM_CHARS = 4;

    typedef enum logic {
        ST_ENTRY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Index 0 of the result is segment a; all segments are active-low.
    function automatic logic [0:6] seg7(input logic [2:0] code);
        logic [0:6] s;
        case (code)
            CH_0:    s = 7'b0000001;
            CH_1:    s = 7'b1001111;
            CH_E:    s = 7'b0110000;
            CH_D:    s = 7'b1000010;
            CH_H:    s = 7'b1001000;
            CH_L:    s = 7'b1110001;
            CH_P:    s = 7'b0011000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/msg_entry_writer_if.sv
// Key event bundle: a one-cycle press pulse from a debouncer to its consumer.
interface msg_key_if;
    logic press;

    modport master (output press);
    modport slave  (input  press);
endinterface

// File: rtl/msg_entry_writer_key_debounce.sv
// One pushbutton: 2-flop synchronizer, stability debouncer and a press
// pulse on the accepted level falling 1->0.
module key_debounce
    import msg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      key_i,
    msg_key_if.master ev
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             acc_q, acc_d;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronized level disagrees; any agreement clears it.
    always_comb begin
        acc_d = acc_q;
        cnt_d = '0;
        if (sync_q[1] != acc_q) begin
            if (cnt_q == CNT_LAST) acc_d = sync_q[1];
            else                   cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            acc_q  <= 1'b1;
            prev_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], key_i};
            acc_q  <= acc_d;
            prev_q <= acc_q;
            cnt_q  <= cnt_d;
        end
    end

    assign ev.press = prev_q & ~acc_q;

endmodule

// File: rtl/msg_entry_writer.sv
// Four-character shift-in message buffer on HEX3..HEX0, written from SW
// by KEY[1] and cleared by KEY[2]; KEY[0] is the asynchronous reset.
module msg_entry_writer
    import msg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic [2:0] KEY,
    input  logic [2:0] SW,
    output logic [0:6] HEX0,
    output logic [0:6] HEX1,
    output logic [0:6] HEX2,
    output logic [0:6] HEX3,
    output logic [3:0] LEDR
);

    logic rst_n;
    assign rst_n = KEY[0];

    msg_key_if wr_if ();
    msg_key_if clr_if ();

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_wr_key (
        .clk   (CLOCK_50),
        .rst_n (rst_n),
        .key_i (KEY[1]),
        .ev    (wr_if)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_key (
        .clk   (CLOCK_50),
        .rst_n (rst_n),
        .key_i (KEY[2]),
        .ev    (clr_if)
    );

    state_e                       state_q, state_d;
    logic [2:0]                   cnt_q, cnt_d;
    logic [NUM_CHARS-1:0][2:0]    chr_q, chr_d;

    // Clear has priority, so a simultaneous write is simply dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chr_d   = chr_q;
        if (clr_if.press) begin
            state_d = ST_ENTRY;
            cnt_d   = '0;
            chr_d   = '0;
        end else if (wr_if.press && state_q == ST_ENTRY) begin
            chr_d = {chr_q[NUM_CHARS-2:0], SW};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(NUM_CHARS - 1)) state_d = ST_FULL;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ENTRY;
            cnt_q   <= '0;
            chr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chr_q   <= chr_d;
        end
    end

    assign HEX0 = seg7(chr_q[0]);
    assign HEX1 = seg7(chr_q[1]);
    assign HEX2 = seg7(chr_q[2]);
    assign HEX3 = seg7(chr_q[3]);
    assign LEDR = {state_q == ST_FULL, cnt_q};

endmodule

// File: tb/tb_msg_entry_writer.sv
// Directed bench for msg_entry_writer with a short debounce window.
module tb_msg_entry_writer;
    import msg_pkg::*;

    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] SE = 7'b0110000;
    localparam logic [6:0] SD = 7'b1000010;
    localparam logic [6:0] SH = 7'b1001000;

    logic       clk = 1'b0;
    logic [2:0] key = 3'b111;
    logic [2:0] sw  = 3'd0;
    logic [0:6] hex0, hex1, hex2, hex3;
    logic [3:0] ledr;

    int n_chk = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    msg_entry_writer #(.DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50 (clk),
        .KEY      (key),
        .SW       (sw),
        .HEX0     (hex0),
        .HEX1     (hex1),
        .HEX2     (hex2),
        .HEX3     (hex3),
        .LEDR     (ledr)
    );

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input logic [6:0] e3, e2, e1, e0,
                            input logic [3:0] led);
        chk({tag, "_hex3"}, hex3, e3);
        chk({tag, "_hex2"}, hex2, e2);
        chk({tag, "_hex1"}, hex1, e1);
        chk({tag, "_hex0"}, hex0, e0);
        chk({tag, "_ledr"}, {3'b000, ledr}, {3'b000, led});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press: long enough low and high phases to debounce both edges.
    task automatic press(input logic wr, input logic clr, input logic [2:0] code);
        sw     = code;
        key[1] = ~wr;
        key[2] = ~clr;
        tick(12);
        key[2:1] = 2'b11;
        tick(12);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        key = 3'b110;
        tick(3);
        chk_disp("reset", SB, SB, SB, SB, 4'b0000);
        key[0] = 1'b1;
        tick(2);

        press(1'b1, 1'b0, CH_D);
        chk("first_cnt", {3'b000, ledr}, 7'd1);
        chk("first_hex0", hex0, SD);
        press(1'b1, 1'b0, CH_E);
        press(1'b1, 1'b0, CH_1);
        press(1'b1, 1'b0, CH_0);
        chk_disp("full", SD, SE, S1, S0, 4'b1100);

        press(1'b1, 1'b0, CH_H);
        chk_disp("full_wr", SD, SE, S1, S0, 4'b1100);

        press(1'b0, 1'b1, CH_H);
        chk_disp("clear", SB, SB, SB, SB, 4'b0000);

        // Bouncy write of a blank: 2 low, 1 high, 6 low.
        sw = CH_BLANK;
        key[1] = 1'b0; tick(2);
        key[1] = 1'b1; tick(1);
        key[1] = 1'b0; tick(6);
        key[1] = 1'b1; tick(12);
        chk_disp("bounce", SB, SB, SB, SB, 4'b0001);

        // Long hold yields a single write.
        sw = CH_1;
        key[1] = 1'b0; tick(40);
        key[1] = 1'b1; tick(12);
        chk("hold_cnt", {3'b000, ledr}, 7'd2);
        chk("hold_hex0", hex0, S1);
        chk("hold_hex1", hex1, SB);

        press(1'b1, 1'b0, CH_E);
        chk("three_cnt", {3'b000, ledr}, 7'd3);
        press(1'b1, 1'b1, CH_H);
        chk_disp("clr_wr", SB, SB, SB, SB, 4'b0000);

        // Reset two cycles into a debounce window.
        press(1'b1, 1'b0, CH_0);
        chk("pre_rst_cnt", {3'b000, ledr}, 7'd1);
        sw = CH_E;
        key[1] = 1'b0;
        tick(4);
        key[0] = 1'b0;
        #1;
        chk_disp("rst_async", SB, SB, SB, SB, 4'b0000);
        key[1] = 1'b1;
        tick(1);
        key[0] = 1'b1;
        tick(15);
        chk_disp("rst_mid", SB, SB, SB, SB, 4'b0000);

        // Key held low across reset release must still debounce.
        sw = CH_H;
        key[1] = 1'b0;
        key[0] = 1'b0;
        tick(2);
        key[0] = 1'b1;
        tick(4);
        chk("held_early", {3'b000, ledr}, 7'd0);
        tick(10);
        chk("held_late", {3'b000, ledr}, 7'd1);
        chk("held_hex0", hex0, SH);
        key[1] = 1'b1;
        tick(12);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
